// File: rtl/video_timing_gen.sv
// VGA raster timing generator; lock-qualified start, all outputs registered and aligned to x/y.
// Latency: outputs describe the presented x,y in the same cycle; no backpressure (free-running raster).
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0,
  parameter int LOCK_WAIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic       running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW      = (LOCK_WAIT < 2) ? 1 : $clog2(LOCK_WAIT + 1);

  localparam logic [9:0]    HT_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]    VT_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]    HA      = 10'(H_ACTIVE);
  localparam logic [9:0]    VA      = 10'(V_ACTIVE);
  localparam logic [9:0]    HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] LW_LAST = CW'(LOCK_WAIT - 1);
  localparam logic          POL     = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          lk_meta_q, lk_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          run_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic          ls_q, ls_d, fs_q, fs_d, run_q;

  // The counter includes the cycle that left WAIT_LOCK, so running rises
  // exactly LOCK_WAIT synchronised-locked cycles after lk first goes high.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    run_d   = 1'b0;
    x_d     = '0;
    y_d     = '0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lk_q) begin
          if (LOCK_WAIT <= 1) begin
            state_d = RUN;
            run_d   = 1'b1;
          end else begin
            state_d = SETTLE;
            cnt_d   = CW'(1);
          end
        end
      end
      SETTLE: begin
        if (!lk_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == LW_LAST) begin
          state_d = RUN;
          run_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lk_q) begin
          state_d = WAIT_LOCK;
        end else begin
          run_d = 1'b1;
          if (x_q == HT_LAST) begin
            x_d = '0;
            y_d = (y_q == VT_LAST) ? '0 : y_q + 10'd1;
          end else begin
            x_d = x_q + 10'd1;
            y_d = y_q;
          end
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Decode from next-state counters so flopped strobes line up with flopped x/y.
  always_comb begin
    hsync_d = (run_d && x_d >= HS_BEG && x_d < HS_END) ? POL : ~POL;
    vsync_d = (run_d && y_d >= VS_BEG && y_d < VS_END) ? POL : ~POL;
    de_d    = run_d && (x_d < HA) && (y_d < VA);
    ls_d    = run_d && (x_d == 10'd0);
    fs_d    = ls_d && (y_d == 10'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      hsync_q   <= ~POL;
      vsync_q   <= ~POL;
      de_q      <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_q      <= lk_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
      run_q     <= run_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign running     = run_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default instance plus a small SYNC_POL=1 instance checked against a lock-streak model.
module tb_video_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock0, lock1;
  logic       hs0, vs0, de0, ls0, fs0, run0;
  logic       hs1, vs1, de1, ls1, fs1, run1;
  logic [9:0] x0, y0, x1, y1;
  logic [31:0] obs0, obs1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int   st0, st1;
  logic h0a, h0b, h1a, h1b;

  always #5 clk = ~clk;

  video_timing_gen dut0 (
    .clk(clk), .reset_n(rst_n), .pll_locked(lock0),
    .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
    .line_start(ls0), .frame_start(fs0), .running(run0)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1), .LOCK_WAIT(3)
  ) dut1 (
    .clk(clk), .reset_n(rst_n), .pll_locked(lock1),
    .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
    .line_start(ls1), .frame_start(fs1), .running(run1)
  );

  assign obs0 = {6'd0, run0, fs0, ls0, de0, hs0, vs0, x0, y0};
  assign obs1 = {6'd0, run1, fs1, ls1, de1, hs1, vs1, x1, y1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Running after an edge iff the last `lw` synchronised samples were all high;
  // raster position is simply how far past that point the streak has gone.
  function automatic logic [31:0] model_vec(input int dut, input int streak);
    int ha, hf, hs, hb, va, vf, vs, vb, lw, ht, vt, pos, px, py;
    logic pol, hsy, vsy;
    if (dut == 0) begin
      ha = 640; hf = 16; hs = 96; hb = 48; va = 480; vf = 10; vs = 2; vb = 33; lw = 16; pol = 1'b0;
    end else begin
      ha = 8; hf = 2; hs = 3; hb = 3; va = 4; vf = 1; vs = 2; vb = 1; lw = 3; pol = 1'b1;
    end
    if (streak < lw) return {6'd0, 4'b0000, ~pol, ~pol, 20'd0};
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    pos = streak - lw;
    px  = pos % ht;
    py  = (pos / ht) % vt;
    hsy = (px >= ha + hf && px < ha + hf + hs) ? pol : ~pol;
    vsy = (py >= va + vf && py < va + vf + vs) ? pol : ~pol;
    return {6'd0, 1'b1, (px == 0 && py == 0), (px == 0), (px < ha && py < va),
            hsy, vsy, 10'(px), 10'(py)};
  endfunction

  task automatic model_reset();
    st0 = 0; st1 = 0;
    h0a = 1'b0; h0b = 1'b0; h1a = 1'b0; h1b = 1'b0;
    q0.delete(); q1.delete();
  endtask

  task automatic step(input logic l0, input logic l1);
    lock0 = l0;
    lock1 = l1;
    st0 = h0b ? st0 + 1 : 0; h0b = h0a; h0a = l0;
    st1 = h1b ? st1 + 1 : 0; h1b = h1a; h1a = l1;
    q0.push_back(model_vec(0, st0));
    q1.push_back(model_vec(1, st1));
    @(posedge clk);
    #1;
    check("vec0", obs0, q0.pop_front());
    check("vec1", obs1, q1.pop_front());
  endtask

  initial begin
    int n, de_n, hs_n, ls_n, fs_n, vs_n, de1_n;
    logic seen;
    rst_n = 1'b1;
    lock0 = 1'b0;
    lock1 = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst0", obs0, 32'h0030_0000);
    check("rst1", obs1, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock held from the first edge after reset release.
    seen = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step(1'b1, 1'b1);
      if (!seen && run0) begin
        seen = 1'b1;
        check("rise_edge", 32'(e), 32'd18);
        check("first_px", 32'({x0, y0, fs0, ls0, de0}), 32'h0000_0007);
      end
    end
    if (!seen) check("rise_edge", 32'd0, 32'd18);

    // One full line of the default raster.
    n = 0;
    while (!(x0 == 10'd0 && y0 == 10'd1) && n < 2000) begin step(1'b1, 1'b1); n++; end
    check("line_align", 32'(x0 == 10'd0 && y0 == 10'd1), 32'd1);
    de_n = 0; hs_n = 0; ls_n = 0;
    for (int i = 0; i < 800; i++) begin
      de_n += int'(de0);
      hs_n += int'(!hs0);
      ls_n += int'(ls0);
      step(1'b1, 1'b1);
    end
    check("de_cnt", 32'(de_n), 32'd640);
    check("hs_cnt", 32'(hs_n), 32'd96);
    check("ls_cnt", 32'(ls_n), 32'd1);
    check("ls_period", 32'(ls0), 32'd1);

    // One full frame of the small active-high instance.
    n = 0;
    while (!fs1 && n < 300) begin step(1'b1, 1'b1); n++; end
    check("frame_align", 32'(fs1), 32'd1);
    fs_n = 0; vs_n = 0; de1_n = 0;
    for (int i = 0; i < 128; i++) begin
      fs_n  += int'(fs1);
      vs_n  += int'(vs1);
      de1_n += int'(de1);
      step(1'b1, 1'b1);
    end
    check("fs_cnt", 32'(fs_n), 32'd1);
    check("vs_cnt", 32'(vs_n), 32'd32);
    check("de1_cnt", 32'(de1_n), 32'd32);
    check("fs_period", 32'(fs1), 32'd1);

    // Lock glitch while settling restarts the qualification count.
    repeat (5) step(1'b0, 1'b0);
    check("stopped", 32'({run0, x0, y0}), 32'd0);
    repeat (10) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    n = 0;
    do begin step(1'b1, 1'b1); n++; end while (!run0 && n < 40);
    check("resettle", 32'(n), 32'd18);

    // Lock loss mid-frame.
    n = 0;
    while (!(x0 == 10'd300 && y0 == 10'd20) && n < 20000) begin step(1'b1, 1'b1); n++; end
    check("reach_pos", 32'({x0, y0}), 32'({10'd300, 10'd20}));
    n = 0;
    do begin step(1'b0, 1'b1); n++; end while (run0 && n < 10);
    check("drop_lat", 32'(n), 32'd3);
    check("drop_state", 32'({de0, hs0, vs0, ls0, fs0, x0, y0}), 32'({1'b0, 2'b11, 2'b00, 20'd0}));
    n = 0;
    do begin step(1'b1, 1'b1); n++; end while (!run0 && n < 40);
    check("relock", 32'(n), 32'd18);
    check("relock_fs", 32'({fs0, x0, y0}), 32'h0010_0000);

    // Asynchronous reset in the middle of a frame.
    repeat (50) step(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst0", obs0, 32'h0030_0000);
    check("arst1", obs1, 32'h0000_0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
